// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use hazard detection
// with a LOAD_LAT-cycle stall sequencer and saturating stall counter.
module fwd_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_mem_regwrite_i,
  input  logic [AW-1:0]         ex_mem_write_reg_i,
  input  logic                  mem_wb_regwrite_i,
  input  logic [AW-1:0]         mem_wb_write_reg_i,
  input  logic [NUM_SRC*AW-1:0] id_ex_src_i,
  input  logic                  id_ex_memread_i,
  input  logic [AW-1:0]         id_ex_write_reg_i,
  input  logic [NUM_SRC*AW-1:0] if_id_src_i,
  input  logic [NUM_SRC-1:0]    if_id_src_used_i,
  input  logic                  flush_i,
  output logic [2*NUM_SRC-1:0]  forward_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  typedef enum logic {
    IDLE,
    STALL
  } state_e;

  localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_ok, wb_ok;
  logic             hazard;
  logic             stall_raw;
  logic             stall;

  assign ex_ok = ex_mem_regwrite_i
               && (ex_mem_write_reg_i != '0);
  assign wb_ok = mem_wb_regwrite_i
               && (mem_wb_write_reg_i != '0);

  // EX/MEM holds the younger result, so it is checked first
  always_comb begin
    forward_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_ok
          && id_ex_src_i[k*AW +: AW]
             == ex_mem_write_reg_i)
        forward_o[2*k +: 2] = 2'b10;
      else if (wb_ok
               && id_ex_src_i[k*AW +: AW]
                  == mem_wb_write_reg_i)
        forward_o[2*k +: 2] = 2'b01;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (if_id_src_used_i[k]
          && if_id_src_i[k*AW +: AW]
             == id_ex_write_reg_i)
        hazard = 1'b1;
    end
    hazard = hazard && id_ex_memread_i
          && (id_ex_write_reg_i != '0);
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hazard && !flush_i) begin
          stall_raw = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            rem_d   = REM_INIT;
          end
        end
      end
      STALL: begin
        if (flush_i) begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end else begin
          stall_raw = 1'b1;
          if (rem_q == 4'd1) begin
            state_d = IDLE;
            rem_d   = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 4'd0;
      end
    endcase
  end

  // reset must release the pipeline without waiting for a clock
  assign stall = stall_raw & rst_i;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write_o    = ~stall;
  assign if_id_write_o = ~stall;
  assign id_ex_flush_o = stall;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=3/CNT_W=4 and
// LOAD_LAT=1/CNT_W=3) driven identically, checked against a model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       erw, mrw, mr, fl;
  logic [4:0] erd, mrd, ird;
  logic [9:0] isrc, fsrc;
  logic [1:0] used;

  logic [3:0] a_fwd, b_fwd;
  logic       a_pcw, a_ifw, a_fl;
  logic       b_pcw, b_ifw, b_fl;
  logic [3:0] a_cnt;
  logic [2:0] b_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .NUM_SRC(2), .AW(5), .LOAD_LAT(3), .CNT_W(4)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .ex_mem_regwrite_i(erw), .ex_mem_write_reg_i(erd),
    .mem_wb_regwrite_i(mrw), .mem_wb_write_reg_i(mrd),
    .id_ex_src_i(isrc), .id_ex_memread_i(mr),
    .id_ex_write_reg_i(ird), .if_id_src_i(fsrc),
    .if_id_src_used_i(used), .flush_i(fl),
    .forward_o(a_fwd), .pc_write_o(a_pcw),
    .if_id_write_o(a_ifw), .id_ex_flush_o(a_fl),
    .stall_cnt_o(a_cnt)
  );

  fwd_hazard_unit #(
    .NUM_SRC(2), .AW(5), .LOAD_LAT(1), .CNT_W(3)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .ex_mem_regwrite_i(erw), .ex_mem_write_reg_i(erd),
    .mem_wb_regwrite_i(mrw), .mem_wb_write_reg_i(mrd),
    .id_ex_src_i(isrc), .id_ex_memread_i(mr),
    .id_ex_write_reg_i(ird), .if_id_src_i(fsrc),
    .if_id_src_used_i(used), .flush_i(fl),
    .forward_o(b_fwd), .pc_write_o(b_pcw),
    .if_id_write_o(b_ifw), .id_ex_flush_o(b_fl),
    .stall_cnt_o(b_cnt)
  );

  typedef struct {
    logic [3:0] f;
    bit         sa;
    bit         sb;
    int         ca;
    int         cb;
  } exp_t;

  typedef struct {
    bit         r;
    bit         erw;
    logic [4:0] erd;
    bit         mrw;
    logic [4:0] mrd;
    logic [9:0] isrc;
    bit         mr;
    logic [4:0] ird;
    logic [9:0] fsrc;
    logic [1:0] u;
    bit         fl;
  } stim_t;

  exp_t  q[$];
  exp_t  mon_e;
  stim_t s;
  int    n_chk = 0;
  int    n_fail = 0;

  // model: cycles of stall still owed after the current one
  int left_a = 0, left_b = 0;
  int nleft_a = 0, nleft_b = 0;
  int cnt_a = 0, cnt_b = 0;
  bit st_a = 0, st_b = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fwd_model();
    logic [3:0] r;
    logic [4:0] src;
    r = 4'b0;
    for (int k = 0; k < 2; k++) begin
      src = isrc[k*5 +: 5];
      if (erw && erd != 0 && erd == src)
        r[2*k +: 2] = 2'b10;
      else if (mrw && mrd != 0 && mrd == src)
        r[2*k +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit hz_model();
    bit h;
    logic [4:0] src;
    h = 0;
    for (int k = 0; k < 2; k++) begin
      src = fsrc[k*5 +: 5];
      if (used[k] && src == ird) h = 1;
    end
    return h && mr && ird != 0;
  endfunction

  task automatic model_stall(input int lat,
                             input int left,
                             output bit st,
                             output int nleft);
    if (left > 0) begin
      st    = !fl;
      nleft = fl ? 0 : left - 1;
    end else begin
      st    = hz_model() && !fl;
      nleft = st ? lat - 1 : 0;
    end
    if (!rst) begin
      st    = 0;
      nleft = 0;
    end
  endtask

  task automatic tick(input stim_t t);
    @(posedge clk);
    if (rst) begin
      cnt_a  = (cnt_a + st_a > 15) ? 15 : cnt_a + st_a;
      cnt_b  = (cnt_b + st_b > 7) ? 7 : cnt_b + st_b;
      left_a = nleft_a;
      left_b = nleft_b;
    end
    #1;
    rst  = t.r;
    erw  = t.erw;
    erd  = t.erd;
    mrw  = t.mrw;
    mrd  = t.mrd;
    isrc = t.isrc;
    mr   = t.mr;
    ird  = t.ird;
    fsrc = t.fsrc;
    used = t.u;
    fl   = t.fl;
    if (!rst) begin
      left_a = 0;
      left_b = 0;
      cnt_a  = 0;
      cnt_b  = 0;
    end
    model_stall(3, left_a, st_a, nleft_a);
    model_stall(1, left_b, st_b, nleft_b);
    q.push_back('{fwd_model(), st_a, st_b, cnt_a, cnt_b});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("fwd_a", 32'(a_fwd), 32'(mon_e.f));
        chk("fwd_b", 32'(b_fwd), 32'(mon_e.f));
        chk("pcw_a", 32'(a_pcw), 32'(!mon_e.sa));
        chk("ifw_a", 32'(a_ifw), 32'(!mon_e.sa));
        chk("bub_a", 32'(a_fl), 32'(mon_e.sa));
        chk("pcw_b", 32'(b_pcw), 32'(!mon_e.sb));
        chk("ifw_b", 32'(b_ifw), 32'(!mon_e.sb));
        chk("bub_b", 32'(b_fl), 32'(mon_e.sb));
        chk("cnt_a", 32'(a_cnt), 32'(mon_e.ca));
        chk("cnt_b", 32'(b_cnt), 32'(mon_e.cb));
      end
    end
  end

  initial begin
    {erw, mrw, mr, fl} = '0;
    {erd, mrd, ird} = '0;
    {isrc, fsrc} = '0;
    used = '0;
    s = '{default: '0};
    tick(s);
    tick(s);
    s.r = 1;
    tick(s);
    // forwarding priority and register zero
    s.erw = 1; s.erd = 5; s.mrw = 1; s.mrd = 5;
    s.isrc = {5'd6, 5'd5};
    tick(s);
    s.mrd = 6;
    tick(s);
    s.erd = 0; s.mrd = 0; s.isrc = 0;
    tick(s);
    // load into r0 never stalls
    s.mr = 1; s.ird = 0; s.fsrc = 0; s.u = 2'b11;
    tick(s);
    s.mr = 0;
    tick(s);
    // load-use on operand 1
    s.mr = 1; s.ird = 7;
    s.fsrc = {5'd7, 5'd3}; s.u = 2'b10;
    tick(s);
    s.mr = 0;
    repeat (4) tick(s);
    s.mr = 1; s.u = 2'b01;
    tick(s);
    s.mr = 0;
    repeat (2) tick(s);
    // flush in second stall cycle
    s.mr = 1; s.u = 2'b10;
    tick(s);
    s.mr = 0; s.fl = 1;
    tick(s);
    s.fl = 0;
    repeat (3) tick(s);
    // reset during stall
    s.mr = 1;
    tick(s);
    s.mr = 0; s.r = 0;
    repeat (2) tick(s);
    s.r = 1;
    repeat (3) tick(s);
    // saturation
    repeat (10) begin
      s.mr = 1;
      tick(s);
      s.mr = 0;
      repeat (3) tick(s);
    end
    repeat (3000) begin
      s.r    = ($urandom_range(0, 99) != 0);
      s.erw  = 1'($urandom);
      s.erd  = 5'($urandom_range(0, 7));
      s.mrw  = 1'($urandom);
      s.mrd  = 5'($urandom_range(0, 7));
      s.isrc = {5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7))};
      s.mr   = 1'($urandom);
      s.ird  = 5'($urandom_range(0, 7));
      s.fsrc = {5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7))};
      s.u    = 2'($urandom);
      s.fl   = ($urandom_range(0, 7) == 0);
      tick(s);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised successor of the pipeline's two-operand forwarding logic. Combines per-operand EX/MEM and MEM/WB forwarding selection for NUM_SRC source operands with load-use hazard detection and a multi-cycle stall sequencer. The stall length is sized to the data-memory load latency. Sits between the ID and EX stages: forwarding selects drive the EX operand muxes, and stall controls drive the PC, IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- NUM_SRC, 2, number of source operands per instruction (1..4)
- AW, 5, register-address width
- LOAD_LAT, 1, stall cycles per load-use hazard (1..15)
- CNT_W, 16, width of stall statistics counter

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- ex_mem_regwrite_i  in  1  EX/MEM stage writes a register
- ex_mem_write_reg_i  in  AW  EX/MEM destination register
- mem_wb_regwrite_i  in  1  MEM/WB stage writes a register
- mem_wb_write_reg_i  in  AW  MEM/WB destination register
- id_ex_src_i  in  NUM_SRC*AW  ID/EX source registers, operand k at bits [k*AW +: AW]
- id_ex_memread_i  in  1  instruction in ID/EX is a load
- id_ex_write_reg_i  in  AW  ID/EX destination register
- if_id_src_i  in  NUM_SRC*AW  source registers of the instruction in IF/ID, same packing
- if_id_src_used_i  in  NUM_SRC  bit k set: IF/ID operand k is actually read
- flush_i  in  1  control-flow flush (taken branch/jump) this cycle
- forward_o  out  2*NUM_SRC  operand k select at bits [2k +: 2]: 00 regfile, 10 EX/MEM, 01 MEM/WB
- pc_write_o  out  1  PC update enable
- if_id_write_o  out  1  IF/ID register write enable
- id_ex_flush_o  out  1  insert bubble into ID/EX
- stall_cnt_o  out  CNT_W  total stall cycles since reset, saturating

## Operation
- Forwarding, per operand k, purely combinational:
  - Select 10 if ex_mem_regwrite_i, ex_mem_write_reg_i != 0, and it equals src k.
  - Else select 01 if the same conditions hold for MEM/WB.
  - Else select 00.
  - EX/MEM always wins over MEM/WB.
- Hazard condition: id_ex_memread_i, id_ex_write_reg_i != 0, and for some k, if_id_src_used_i[k] is set and if_id_src k equals id_ex_write_reg_i.
- FSM states: IDLE and STALL. A down-counter `rem` is 4 bits wide.
- IDLE:
  - With hazard and !flush_i, stall is asserted this cycle.
  - If LOAD_LAT > 1, go to STALL with rem = LOAD_LAT-1. Otherwise stay in IDLE.
  - With flush_i, hazard detection is suppressed and there is no stall.
- STALL:
  - Stall is asserted and hazard inputs are ignored.
  - If rem == 1, go to IDLE. Otherwise rem decrements.
  - With flush_i, go to IDLE immediately, clear rem, and do not assert stall that cycle.
- Stall asserted means: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1. Otherwise these are 1, 1, 0.
- stall_cnt_o increments on every clock edge where stall was asserted. It saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Reset (rst_i=0), asynchronous:
  - State goes to IDLE, rem=0, stall_cnt_o=0.
  - Stall outputs are forced inactive (pc_write_o=1, if_id_write_o=1, id_ex_flush_o=0).
  - forward_o stays combinational from its inputs.
- Reset asserted mid-stall aborts the stall immediately, without waiting for a clock.
- forward_o has zero latency: it is a function of the current inputs only.
- Stall appears in the same cycle the hazard is seen.
- Each hazard produces exactly LOAD_LAT consecutive stalled cycles, unless cut short by flush_i.
- A new hazard can be taken in the first IDLE cycle after STALL, so back-to-back stalls are allowed.
- stall_cnt_o lags the stall by one cycle (registered count).

## Test plan
- Forwarding priority: NUM_SRC=2, EX/MEM and MEM/WB both write r5, id_ex src0=r5, src1=r6 -> forward_o=4'b0010. With MEM/WB only writing r6 -> forward_o=4'b0110.
- Register zero: both stages write r0, srcs=r0 -> forward_o=0. Load to r0 used by IF/ID -> no stall.
- Load-use, LOAD_LAT=3: load r7 in ID/EX, IF/ID src1=r7 with used=1 -> exactly 3 cycles of pc_write_o=0 and id_ex_flush_o=1, then IDLE; stall_cnt_o=3. Same case with used=0 -> no stall.
- Flush: LOAD_LAT=3, flush_i pulsed in the 2nd stall cycle -> stall deasserted that cycle, IDLE next cycle, stall_cnt_o=1.
- Reset mid-stall: rst_i low during STALL -> outputs inactive asynchronously and stall_cnt_o=0. After release, no stall until a new hazard.
- Saturation: CNT_W=3, 10 single-cycle hazards -> stall_cnt_o holds 7.
